// File: rtl/layer_sequencer_pkg.sv
// Shared encodings, widths and the network layer table for the layer sequencer.
package layer_sequencer_pkg;

    localparam int NUM_LAYERS_DEF  = 5;
    localparam int LAYER_NUM_W     = 3;
    localparam int FM_SIZE_W       = 8;
    localparam int KERNEL_SIZE_W   = 8;
    localparam int KERNEL_NUM_W    = 8;
    localparam int PADDING_NUM_W   = 4;
    localparam int POOL_SIZE_W     = 4;

    typedef enum logic [1:0] {
        LT_PREP = 2'd0,
        LT_CONV = 2'd1,
        LT_POOL = 2'd2,
        LT_FC   = 2'd3
    } layer_type_e;

    typedef enum logic [1:0] {
        ACT_NONE = 2'd0,
        ACT_RELU = 2'd1
    } act_e;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_NEXT = 3'd3,
        ST_DONE = 3'd4
    } seq_state_e;

    typedef struct packed {
        layer_type_e                layer_type;
        logic [FM_SIZE_W-1:0]       fm_size;
        logic [KERNEL_SIZE_W-1:0]   fm_depth;
        logic [FM_SIZE_W-1:0]       fm_size_out;
        logic [PADDING_NUM_W-1:0]   padding_out;
        logic [KERNEL_NUM_W-1:0]    kernel_num;
        logic [KERNEL_SIZE_W-1:0]   kernel_size;
        pool_e                      pool_type;
        logic [POOL_SIZE_W-1:0]     pool_win_size;
        act_e                       activation;
    } layer_cfg_t;

    localparam layer_cfg_t CFG_ZERO = '0;

    localparam layer_cfg_t L0_CFG = '{layer_type: LT_PREP, fm_size: 8'd28, fm_depth: 8'd1,
        fm_size_out: 8'd28, padding_out: 4'd0, kernel_num: 8'd0, kernel_size: 8'd0,
        pool_type: POOL_MAX, pool_win_size: 4'd0, activation: ACT_NONE};
    localparam layer_cfg_t L1_CFG = '{layer_type: LT_CONV, fm_size: 8'd28, fm_depth: 8'd1,
        fm_size_out: 8'd24, padding_out: 4'd0, kernel_num: 8'd20, kernel_size: 8'd5,
        pool_type: POOL_MAX, pool_win_size: 4'd0, activation: ACT_RELU};
    localparam layer_cfg_t L2_CFG = '{layer_type: LT_CONV, fm_size: 8'd24, fm_depth: 8'd20,
        fm_size_out: 8'd20, padding_out: 4'd0, kernel_num: 8'd20, kernel_size: 8'd5,
        pool_type: POOL_MAX, pool_win_size: 4'd0, activation: ACT_RELU};
    localparam layer_cfg_t L3_CFG = '{layer_type: LT_POOL, fm_size: 8'd20, fm_depth: 8'd20,
        fm_size_out: 8'd10, padding_out: 4'd0, kernel_num: 8'd20, kernel_size: 8'd0,
        pool_type: POOL_MAX, pool_win_size: 4'd2, activation: ACT_NONE};
    localparam layer_cfg_t L4_CFG = '{layer_type: LT_FC, fm_size: 8'd10, fm_depth: 8'd20,
        fm_size_out: 8'd1, padding_out: 4'd0, kernel_num: 8'd10, kernel_size: 8'd10,
        pool_type: POOL_MAX, pool_win_size: 4'd0, activation: ACT_NONE};

endpackage

// File: rtl/layer_sequencer_if.sv
// Control handshake and per-layer configuration bundle between the sequencer and its neighbours.
interface layer_sequencer_if import layer_sequencer_pkg::*; #(
    parameter int LAYER_NUM_WIDTH   = LAYER_NUM_W,
    parameter int FM_SIZE_WIDTH     = FM_SIZE_W,
    parameter int KERNEL_SIZE_WIDTH = KERNEL_SIZE_W,
    parameter int KERNEL_NUM_WIDTH  = KERNEL_NUM_W,
    parameter int PADDING_NUM_WIDTH = PADDING_NUM_W,
    parameter int POOL_SIZE_WIDTH   = POOL_SIZE_W
);
    logic                           transmission_start;
    logic                           init_fm_ram_ready;
    logic                           init_weight_ram_ready;
    logic                           layer_ready;

    logic                           init;
    logic                           layer_start;
    logic [LAYER_NUM_WIDTH-1:0]     layer_num;
    logic [1:0]                     layer_type;
    logic [1:0]                     pre_layer_type;
    logic [FM_SIZE_WIDTH-1:0]       fm_size;
    logic [FM_SIZE_WIDTH-1:0]       fm_size_out;
    logic [KERNEL_SIZE_WIDTH-1:0]   fm_depth;
    logic [KERNEL_SIZE_WIDTH-1:0]   kernel_size;
    logic [KERNEL_NUM_WIDTH-1:0]    kernel_num;
    logic [PADDING_NUM_WIDTH-1:0]   padding_out;
    logic                           pool_type;
    logic [POOL_SIZE_WIDTH-1:0]     pool_win_size;
    logic [1:0]                     activation;
    logic                           busy;
    logic                           net_done;

    modport master (
        input  transmission_start, init_fm_ram_ready, init_weight_ram_ready, layer_ready,
        output init, layer_start, layer_num, layer_type, pre_layer_type, fm_size, fm_size_out,
               fm_depth, kernel_size, kernel_num, padding_out, pool_type, pool_win_size,
               activation, busy, net_done
    );

    modport slave (
        output transmission_start, init_fm_ram_ready, init_weight_ram_ready, layer_ready,
        input  init, layer_start, layer_num, layer_type, pre_layer_type, fm_size, fm_size_out,
               fm_depth, kernel_size, kernel_num, padding_out, pool_type, pool_win_size,
               activation, busy, net_done
    );
endinterface

// File: rtl/layer_sequencer_config_rom.sv
// Combinational network table: layer index in, configuration bundle out (zeros off the end).
module layer_config_rom import layer_sequencer_pkg::*; #(
    parameter int LAYER_NUM_WIDTH = LAYER_NUM_W
) (
    input  logic [LAYER_NUM_WIDTH-1:0] layer_num,
    output layer_cfg_t                 cfg
);
    always_comb begin
        cfg = CFG_ZERO;
        case (int'(layer_num))
            0:       cfg = L0_CFG;
            1:       cfg = L1_CFG;
            2:       cfg = L2_CFG;
            3:       cfg = L3_CFG;
            4:       cfg = L4_CFG;
            default: cfg = CFG_ZERO;
        endcase
    end
endmodule

// File: rtl/layer_sequencer.sv
// Walks the network table one layer at a time, presenting registered config and start pulses.
//   state | meaning
//   IDLE  | waiting for transmission_start
//   LOAD  | config registered, layer_start (and init for layer 0) asserted
//   RUN   | waiting for the current layer's completion
//   NEXT  | advance layer index or finish
//   DONE  | net_done held until transmission_start drops
module layer_sequencer import layer_sequencer_pkg::*; #(
    parameter int NUM_LAYERS        = NUM_LAYERS_DEF,
    parameter int LAYER_NUM_WIDTH   = LAYER_NUM_W,
    parameter int FM_SIZE_WIDTH     = FM_SIZE_W,
    parameter int KERNEL_SIZE_WIDTH = KERNEL_SIZE_W,
    parameter int KERNEL_NUM_WIDTH  = KERNEL_NUM_W,
    parameter int PADDING_NUM_WIDTH = PADDING_NUM_W,
    parameter int POOL_SIZE_WIDTH   = POOL_SIZE_W
) (
    input  logic                clk,
    input  logic                rst,
    layer_sequencer_if.master   bus
);
    localparam logic [LAYER_NUM_WIDTH-1:0] LAST_LAYER = LAYER_NUM_WIDTH'(NUM_LAYERS - 1);

    seq_state_e                  state, state_next;
    logic [LAYER_NUM_WIDTH-1:0]  layer_num_q, layer_num_next;
    layer_type_e                 pre_type_q, pre_type_next;
    layer_cfg_t                  cfg_q, rom_cfg;
    logic                        layer_start_q, init_q, busy_q, net_done_q;
    logic                        layer_complete;

    // The ROM looks ahead at the index being entered so config lands together with LOAD.
    layer_config_rom #(.LAYER_NUM_WIDTH(LAYER_NUM_WIDTH)) u_rom (
        .layer_num (layer_num_next),
        .cfg       (rom_cfg)
    );

    always_comb begin
        state_next     = state;
        layer_num_next = layer_num_q;
        pre_type_next  = pre_type_q;
        layer_complete = (cfg_q.layer_type == LT_PREP) ?
                         (bus.init_fm_ram_ready & bus.init_weight_ram_ready) : bus.layer_ready;
        case (state)
            ST_IDLE: begin
                if (bus.transmission_start) begin
                    state_next     = ST_LOAD;
                    layer_num_next = '0;
                    pre_type_next  = LT_PREP;
                end
            end
            ST_LOAD: state_next = ST_RUN;
            ST_RUN: begin
                if (layer_complete) state_next = ST_NEXT;
            end
            ST_NEXT: begin
                if (layer_num_q == LAST_LAYER) begin
                    state_next = ST_DONE;
                end else begin
                    state_next     = ST_LOAD;
                    pre_type_next  = cfg_q.layer_type;
                    layer_num_next = layer_num_q + LAYER_NUM_WIDTH'(1);
                end
            end
            ST_DONE: begin
                if (!bus.transmission_start) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            layer_num_q   <= '0;
            pre_type_q    <= LT_PREP;
            cfg_q         <= CFG_ZERO;
            layer_start_q <= 1'b0;
            init_q        <= 1'b0;
            busy_q        <= 1'b0;
            net_done_q    <= 1'b0;
        end else begin
            state         <= state_next;
            layer_num_q   <= layer_num_next;
            pre_type_q    <= pre_type_next;
            if (state_next == ST_LOAD) cfg_q <= rom_cfg;
            layer_start_q <= (state_next == ST_LOAD);
            init_q        <= (state_next == ST_LOAD) && (layer_num_next == '0);
            busy_q        <= (state_next == ST_LOAD) || (state_next == ST_RUN) ||
                             (state_next == ST_NEXT);
            net_done_q    <= (state_next == ST_DONE);
        end
    end

    assign bus.init           = init_q;
    assign bus.layer_start    = layer_start_q;
    assign bus.busy           = busy_q;
    assign bus.net_done       = net_done_q;
    assign bus.layer_num      = layer_num_q;
    assign bus.pre_layer_type = pre_type_q;
    assign bus.layer_type     = cfg_q.layer_type;
    assign bus.fm_size        = FM_SIZE_WIDTH'(cfg_q.fm_size);
    assign bus.fm_size_out    = FM_SIZE_WIDTH'(cfg_q.fm_size_out);
    assign bus.fm_depth       = KERNEL_SIZE_WIDTH'(cfg_q.fm_depth);
    assign bus.kernel_size    = KERNEL_SIZE_WIDTH'(cfg_q.kernel_size);
    assign bus.kernel_num     = KERNEL_NUM_WIDTH'(cfg_q.kernel_num);
    assign bus.padding_out    = PADDING_NUM_WIDTH'(cfg_q.padding_out);
    assign bus.pool_type      = cfg_q.pool_type;
    assign bus.pool_win_size  = POOL_SIZE_WIDTH'(cfg_q.pool_win_size);
    assign bus.activation     = cfg_q.activation;
endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Per-network layer sequencer that drives the layer-parameter / compute stage. On `transmission_start` it walks layers 0..NUM_LAYERS-1 in order. For each layer it presents a registered configuration word (layer number, type, previous type, geometry, kernel, pool and activation settings) together with a one-cycle `layer_start`, then waits for that layer's completion before advancing. Layer 0 is the data-preparation layer: it issues `init` to the data-transmission stage and completes when both initial RAMs report ready. `net_done` flags the end of the network.

## Interface
Parameters:
- NUM_LAYERS, 5, layers in the network table
- LAYER_NUM_WIDTH, 3, width of layer index
- FM_SIZE_WIDTH, 8, feature-map side length width
- KERNEL_SIZE_WIDTH, 8, kernel size / fm depth width
- KERNEL_NUM_WIDTH, 8, kernel count width
- PADDING_NUM_WIDTH, 4, padding width
- POOL_SIZE_WIDTH, 4, pool window width

Ports. One clock; reset is synchronous and active-high (`clk`, `rst`).
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- transmission_start  in  1  level; run request
- init_fm_ram_ready  in  1  initial fm RAM loaded
- init_weight_ram_ready  in  1  initial weight RAM loaded
- layer_ready  in  1  current compute layer finished (pulse or level)
- init  out  1  one-cycle pulse to data transmission at layer 0 start
- layer_start  out  1  one-cycle pulse; config outputs valid
- layer_num  out  LAYER_NUM_WIDTH  current layer index
- layer_type  out  2  0 prep, 1 conv, 2 pool, 3 fc
- pre_layer_type  out  2  type of previous layer (0 at layer 0)
- fm_size, fm_size_out  out  FM_SIZE_WIDTH  input / output fm side (output includes padding)
- fm_depth, kernel_size  out  KERNEL_SIZE_WIDTH
- kernel_num  out  KERNEL_NUM_WIDTH  output depth
- padding_out  out  PADDING_NUM_WIDTH
- pool_type  out  1  0 max, 1 avg
- pool_win_size  out  POOL_SIZE_WIDTH
- activation  out  2  0 none, 1 ReLU
- busy  out  1  state is neither IDLE nor DONE
- net_done  out  1  level, held in DONE

## Operation
- States: IDLE, LOAD, RUN, NEXT, DONE.
- IDLE: if `transmission_start`, go to LOAD with layer_num=0 and pre_layer_type=0.
- Entering LOAD: load all config registers from the table entry for layer_num.
- LOAD (1 cycle): `layer_start`=1. `init`=1 only when layer_num==0. Then go to RUN.
- RUN: completion condition is `init_fm_ram_ready & init_weight_ram_ready` for type 0, and `layer_ready` for all other types. Inputs are sampled only in RUN. On completion go to NEXT.
- NEXT: if layer_num==NUM_LAYERS-1, go to DONE. Otherwise set pre_layer_type<=layer_type, increment layer_num and go to LOAD.
- DONE: `net_done`=1. Stay until `transmission_start`==0, then go to IDLE. Config outputs hold their last values.
- `transmission_start` deassertion while busy is ignored; only `rst` aborts.
- Table (type, fm, depth, fm_out, pad, kn, ks, pool, win, act):
  - L0: 0, 28, 1, 28, 0, 0, 0, 0, 0, 0
  - L1: 1, 28, 1, 24, 0, 20, 5, 0, 0, 1
  - L2: 1, 24, 20, 20, 0, 20, 5, 0, 0, 1
  - L3: 2, 20, 20, 10, 0, 20, 0, 0, 2, 0
  - L4: 3, 10, 20, 1, 0, 10, 10, 0, 0, 0
- Indices ≥NUM_LAYERS are unreachable. The table default returns all zeros.

## Timing
- Reset: state IDLE; every output 0, including config outputs, `init`, `layer_start`, `net_done` and `busy`. Reset mid-layer returns to IDLE the next cycle with no further pulses.
- Start: `transmission_start` sampled high in IDLE at cycle N gives LOAD at N+1, with `layer_start`, `init` and layer-0 config all valid at N+1.
- Completion sampled at cycle M gives NEXT at M+1 and the next layer's LOAD/`layer_start` at M+2.
- Completion after the last layer at M gives `net_done` high at M+2.
- Completion already true on the first RUN cycle is accepted: zero-wait layer takes 3 cycles per layer.
- Config outputs change only on entry to LOAD and are stable through RUN/NEXT.

## Structure
- Shared header/package holds layer-type encodings (PREP/CONV/POOL/FC), activation and pool encodings, width macros and the network table constants.
- One natural sub-module: `layer_config_rom`, a combinational case on layer_num returning the config bundle. The FSM registers its outputs.

## Test plan
- Reset check: `rst` held 3 cycles → all outputs 0, state IDLE. Release with `transmission_start`=0 → no pulses for 20 cycles.
- Layer 0 start and prep completion: `transmission_start`=1 at cycle 5 → `init` and `layer_start` at cycle 6 with layer_num=0, fm_size=28. Raise fm ready at 10 and weight ready at 14 → `layer_start` at 16 with layer_num=1, kernel_size=5, kernel_num=20, pre_layer_type=0.
- Full run: `layer_ready` tied 1 after prep → layers 1..4 start every 3 cycles. The pool layer shows win=2, fm_out=10, pre_type=1. `net_done` goes high 2 cycles after the L4 completion. `init` pulses exactly once.
- Ignored layer_ready outside RUN: `layer_ready` pulsed during LOAD and IDLE → ignored, with no layer advance.
- Reset mid-run: `rst` asserted during L2 RUN → IDLE and all outputs 0 next cycle. Re-start begins again at layer 0 with `init`.
- DONE hold and rerun: hold `transmission_start` in DONE → `net_done` stays 1. Drop it, then raise it again → IDLE, then a new run from layer 0.
